// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-outstanding memory port between the instruction fetch
// port (if_*) and the load/store port (ls_*).
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   if_req/if_addr    : fetch request (held until if_gnt) and address
//   if_flush          : discard any in-flight fetch response
//   if_gnt            : fetch request accepted by memory this cycle
//   if_valid/if_rdata : one-cycle fetch response pulse and data
//   fetch_stall       : if_req high while if_valid low
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata : load/store request fields
//   ls_gnt            : load/store accepted this cycle
//   ls_valid/ls_rdata : one-cycle load/store response pulse and load data
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata : memory request, muxed from winner
//   mem_ready         : memory accepts mem_req this cycle
//   mem_rvalid/mem_rdata : memory response, one per accepted request
//   dbg_state         : FSM state (0 IDLE, 1 IF_BUSY, 2 LS_BUSY)
//   dbg_starve_cnt    : consecutive load/store wins while fetch was waiting
//
// Handshake: a requester raises *_req and holds its fields stable until it
// sees *_gnt; a grant happens only in a cycle where mem_req && mem_ready.
// Each grant produces exactly one *_valid pulse later (unless a fetch is
// flushed), and at most one memory transaction is ever outstanding.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        fetch_stall,
    // load/store port
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    // memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    // debug
    output logic [1:0]  dbg_state,
    output logic [3:0]  dbg_starve_cnt
);

    typedef logic [31:0] data_bus_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_LS_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    state_t    r_state;
    state_t    w_state_nxt;
    logic [3:0] r_starve_cnt;
    logic      r_drop;
    logic      r_if_valid;
    logic      r_ls_valid;
    data_bus_t r_if_rdata;
    data_bus_t r_ls_rdata;

    logic      w_fetch_wins;
    logic      w_any_req;
    logic      w_if_resp;
    logic      w_ls_resp;

    // Load/store normally wins; fetch wins when alone or once it has been
    // passed over STARVE_LIMIT times in a row.
    assign w_fetch_wins = if_req & (~ls_req | (r_starve_cnt == LP_LIMIT));
    assign w_any_req    = if_req | ls_req;

    // Responses only count while the matching transaction is outstanding;
    // mem_rvalid in IDLE is ignored.
    assign w_if_resp = (r_state == ST_IF_BUSY) & mem_rvalid;
    assign w_ls_resp = (r_state == ST_LS_BUSY) & mem_rvalid;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state, request mux and grants
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_be      = 4'h0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Reset masks the request so nothing is granted mid-reset.
                if (!rst) begin
                    mem_req = w_any_req;
                    if (w_fetch_wins) begin
                        mem_be   = 4'hF;
                        mem_addr = if_addr;
                    end else if (ls_req) begin
                        mem_we    = ls_we;
                        mem_be    = ls_be;
                        mem_addr  = ls_addr;
                        mem_wdata = ls_wdata;
                    end
                    if (w_any_req && mem_ready) begin
                        if (w_fetch_wins) begin
                            if_gnt      = 1'b1;
                            w_state_nxt = ST_IF_BUSY;
                        end else begin
                            ls_gnt      = 1'b1;
                            w_state_nxt = ST_LS_BUSY;
                        end
                    end
                end
            end
            ST_IF_BUSY: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LS_BUSY: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Starvation counter, flush-drop flag, response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
            r_drop       <= 1'b0;
            r_if_valid   <= 1'b0;
            r_ls_valid   <= 1'b0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
        end else begin
            r_if_valid <= 1'b0;
            r_ls_valid <= 1'b0;

            if (if_gnt) begin
                r_starve_cnt <= 4'd0;
            end else if (ls_gnt && if_req && (r_starve_cnt < LP_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            // A flush on the response cycle itself also drops that response.
            if (w_if_resp) begin
                r_drop <= 1'b0;
            end else if (if_flush && (if_gnt || (r_state == ST_IF_BUSY))) begin
                r_drop <= 1'b1;
            end

            if (w_if_resp && !(r_drop || if_flush)) begin
                r_if_rdata <= mem_rdata;
                r_if_valid <= 1'b1;
            end

            if (w_ls_resp) begin
                r_ls_rdata <= mem_rdata;
                r_ls_valid <= 1'b1;
            end
        end
    end

    assign if_valid       = r_if_valid;
    assign if_rdata       = r_if_rdata;
    assign ls_valid       = r_ls_valid;
    assign ls_rdata       = r_ls_rdata;
    assign fetch_stall    = if_req & ~r_if_valid;
    assign dbg_state      = r_state;
    assign dbg_starve_cnt = r_starve_cnt;

endmodule
